// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two masters and the memory.
//   a_* / b_*  : request fields (req, we, addr, wdata) in; ack, err, rdata out
//   mem_*      : memory Address / WriteData / MemWrite / MemRead out,
//                ReadData (combinational) in
// Modports: slave = arbiter side, master = masters + memory side.
interface dmem_port_arbiter_if #(parameter int DATA_W = 32);
  logic              a_req, a_we, a_ack, a_err;
  logic [DATA_W-1:0] a_addr, a_wdata, a_rdata;
  logic              b_req, b_we, b_ack, b_err;
  logic [DATA_W-1:0] b_addr, b_wdata, b_rdata;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              mem_write, mem_read;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_err, a_rdata,
    output b_ack, b_err, b_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_err, a_rdata,
    input  b_ack, b_err, b_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port word memory.
// Port A (index 0) = pipeline MEM stage, port B (index 1) = debug/loader.
// One word access per grant: IDLE -> ACCESS (one cycle) -> IDLE, ack pulse
// in the cycle after ACCESS, so peak rate is one access per two cycles.
// Ports:
//   clk    rising-edge FSM (memory writes on the falling edge)
//   rst_n  asynchronous active-low reset
//   bus    dmem_port_arbiter_if.slave (request/response + memory signals)
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN
//   defined   -> A always wins ties (B may starve)
//   undefined -> round-robin, tie goes to the port that was not served last

// Per-port response registers: ack pulse, error flag, held read data.
module dmem_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_i,   // access for this port completes at this edge
  input  logic              load_i,   // completing access is a read
  input  logic              err_i,    // completing access was out of range
  input  logic [DATA_W-1:0] rdata_i,  // already zeroed for out-of-range reads
  output logic              ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic              ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    ack_d   = done_i;
    err_d   = done_i & err_i;
    rdata_d = rdata_q;
    // writes leave the previous read data visible
    if (done_i && load_i) rdata_d = rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
endmodule

module dmem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 32
) (
  input logic                clk,
  input logic                rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int                NP        = 2;
  localparam logic [0:0]        S_IDLE    = 1'b0;
  localparam logic [0:0]        S_ACCESS  = 1'b1;
  localparam logic [DATA_W-1:0] DEPTH_LIM = DATA_W'(DEPTH_WORDS);

  logic [0:0]        state_q, state_d;
  logic              owner_q, owner_d;     // 0 = A, 1 = B
  logic              we_q, we_d;
  logic              inr_q, inr_d;
  logic              rr_last_q, rr_last_d; // last served port
  logic [DATA_W-1:0] addr_q, addr_d;       // doubles as mem_addr (holds in IDLE)
  logic [DATA_W-1:0] wdata_q, wdata_d;     // doubles as mem_wdata

  logic [NP-1:0]             req, req_we, elig, ack, err, done, load, perr;
  logic [NP-1:0][DATA_W-1:0] req_addr, req_wdata, rdata, rdata_in;
  logic                      gnt_vld, gnt_sel;

  assign req       = {bus.b_req,   bus.a_req};
  assign req_we    = {bus.b_we,    bus.a_we};
  assign req_addr  = {bus.b_addr,  bus.a_addr};
  assign req_wdata = {bus.b_wdata, bus.a_wdata};

  // A port acking this cycle is still holding its old req; ignore it at
  // the next edge so it is not served twice.
  assign elig    = req & ~ack;
  assign gnt_vld = (state_q == S_IDLE) && (|elig);

  always_comb begin
    gnt_sel = elig[1];
`ifdef DMEM_ARB_FIXED_PRIO_EN
    gnt_sel = ~elig[0];
`else
    if (&elig) gnt_sel = ~rr_last_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    inr_d     = inr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rr_last_d = rr_last_q;
    if (state_q == S_ACCESS) begin
      state_d   = S_IDLE;
      rr_last_d = owner_q;
    end else if (gnt_vld) begin
      state_d = S_ACCESS;
      owner_d = gnt_sel;
      we_d    = req_we[gnt_sel];
      addr_d  = {req_addr[gnt_sel][DATA_W-1:2], 2'b00};
      wdata_d = req_wdata[gnt_sel];
      inr_d   = (req_addr[gnt_sel] >> 2) < DEPTH_LIM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      inr_q     <= 1'b0;
      rr_last_q <= 1'b1;   // B, so A wins the first tie
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      inr_q     <= inr_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Completion happens at the edge that ends ACCESS.
  assign done     = (state_q == S_ACCESS) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign load     = {NP{~we_q}};
  assign perr     = {NP{~inr_q}};
  assign rdata_in = {NP{inr_q ? bus.mem_rdata : {DATA_W{1'b0}}}};

  dmem_arb_port #(.DATA_W(DATA_W)) u_port [NP-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .done_i  (done),
    .load_i  (load),
    .err_i   (perr),
    .rdata_i (rdata_in),
    .ack_o   (ack),
    .err_o   (err),
    .rdata_o (rdata)
  );

  assign bus.a_ack   = ack[0];
  assign bus.a_err   = err[0];
  assign bus.a_rdata = rdata[0];
  assign bus.b_ack   = ack[1];
  assign bus.b_err   = err[1];
  assign bus.b_rdata = rdata[1];

  // Strobes come straight from state flops, so async reset kills them at once.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = (state_q == S_ACCESS) &  we_q & inr_q;
  assign bus.mem_read  = (state_q == S_ACCESS) & ~we_q & inr_q;
endmodule
